comparator_search_ctrl: RTL and testbench

- Sequential search controller that time-shares one WIDTH-bit equality comparator across a DEPTH-entry word table.
- Scans the table against a latched key, one entry per clock, and reports hit/miss and the matching index through a start/busy/done handshake.
- Used wherever a small lookup or match table is needed without instantiating DEPTH parallel comparators.

---
 rtl/comparator_search_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_comparator_search_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_search_ctrl.sv
// comparator_search_ctrl
// Sequential table search: one WIDTH-bit equality comparator is time-shared
// across a DEPTH-entry word table, one entry per clock, with a
// start/busy/done handshake. Hit/index results are held between searches.
//
// Build option: define COMPARATOR_MATCH_COUNT_EN to always scan the whole
// table and report the number of matching entries on match_count.
//
// DEPTH must be a power of two and at least 2, so that the index wraps
// cleanly and every IDX_W-bit index addresses a real entry.
module comparator_search_ctrl #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [WIDTH-1:0] key,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx
`ifdef COMPARATOR_MATCH_COUNT_EN
  ,
  output logic [IDX_W:0]   match_count
`endif
);

  // state  | meaning
  // S_IDLE | waiting for start; table writes still accepted
  // S_SCAN | comparing entry[idx_q] against key_q, one entry per clock
  // S_DONE | result valid, done pulses for this single cycle
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] table_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] key_q;
  logic [IDX_W-1:0] idx_q;

  logic accept;
  logic in_scan;
  logic cmp_match;
  logic at_last;
  logic scan_end;

  assign accept  = (state_q == S_IDLE) && start;
  assign in_scan = (state_q == S_SCAN);
  assign at_last = (idx_q == LAST_IDX);

  // The single shared comparator. An entry that was never written (or was
  // cleared by reset) can never match, whatever the key.
  assign cmp_match = valid_q[idx_q] && (table_q[idx_q] == key_q);

`ifdef COMPARATOR_MATCH_COUNT_EN
  assign scan_end = at_last;
`else
  assign scan_end = cmp_match || at_last;
`endif

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  // Next-state decode for the search handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (scan_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any scan in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Table storage; writes land at the edge, so a compare of the same entry
  // in the write cycle still sees the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
      valid_q[wr_addr] <= 1'b1;
    end
  end

  // Key latch and scan index; key is captured only on an accepted start so
  // later changes on the key port are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      key_q <= key;
      idx_q <= '0;
    end else if (in_scan && !at_last) begin
      idx_q <= idx_q + 1'b1;
    end
  end

`ifdef COMPARATOR_MATCH_COUNT_EN

  logic             found_q;
  logic [IDX_W-1:0] first_idx_q;
  logic [IDX_W:0]   count_q;

  // Running tally over the full scan; the lowest matching index is kept
  // by recording only the first match seen in ascending order.
  always_ff @(posedge clk) begin
    if (rst) begin
      found_q     <= 1'b0;
      first_idx_q <= '0;
      count_q     <= '0;
    end else if (accept) begin
      found_q     <= 1'b0;
      first_idx_q <= '0;
      count_q     <= '0;
    end else if (in_scan && cmp_match) begin
      count_q <= count_q + 1'b1;
      if (!found_q) begin
        found_q     <= 1'b1;
        first_idx_q <= idx_q;
      end
    end
  end

  assign match_count = count_q;

  // Result registers, loaded only on the edge that enters DONE. The last
  // entry's compare is folded in directly since the tally has not seen it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit     <= 1'b0;
      hit_idx <= '0;
    end else if (in_scan && scan_end) begin
      hit <= found_q || cmp_match;
      if (found_q) begin
        hit_idx <= first_idx_q;
      end else if (cmp_match) begin
        hit_idx <= idx_q;
      end else begin
        hit_idx <= '0;
      end
    end
  end

`else

  // Result registers, loaded only on the edge that enters DONE; the scan
  // stops on the first match so that entry is the lowest matching index.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit     <= 1'b0;
      hit_idx <= '0;
    end else if (in_scan && scan_end) begin
      hit     <= cmp_match;
      hit_idx <= cmp_match ? idx_q : '0;
    end
  end

`endif

endmodule

// File: tb/tb_comparator_search_ctrl.sv
// Testbench for comparator_search_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized searches against a table model.
module tb_comparator_search_ctrl;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int NCYC  = DEPTH + 3;
`ifdef COMPARATOR_MATCH_COUNT_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [WIDTH-1:0] key;
  logic             busy;
  logic             done;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
`ifdef COMPARATOR_MATCH_COUNT_EN
  logic [IDX_W:0]   match_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  comparator_search_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .key     (key),
    .busy    (busy),
    .done    (done),
    .hit     (hit),
    .hit_idx (hit_idx)
`ifdef COMPARATOR_MATCH_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  // Reference table contents
  logic [WIDTH-1:0] m_word  [DEPTH];
  bit               m_valid [DEPTH];

  typedef struct {
    bit               is_search;
    int               addr;
    logic [WIDTH-1:0] data;
    bit               exp_hit;
    int               exp_idx;
    int               exp_cycle;
    int               exp_count;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int count_now();
`ifdef COMPARATOR_MATCH_COUNT_EN
    return int'(match_count);
`else
    return 0;
`endif
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_word[i]  = '0;
      m_valid[i] = 1'b0;
    end
  endfunction

  // Lowest valid match wins; latency is idx+2 on an early-exit hit,
  // otherwise the full table plus the DONE cycle.
  function automatic void model_search(input logic [WIDTH-1:0] k, output bit h,
                                       output int idx, output int cyc, output int cnt);
    h = 1'b0; idx = 0; cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && m_word[i] == k) begin
        if (!h) idx = i;
        h = 1'b1;
        cnt++;
      end
    end
    cyc = (MC || !h) ? DEPTH + 1 : idx + 2;
  endfunction

  task automatic do_write(input int a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = IDX_W'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    m_word[a]  = d;
    m_valid[a] = 1'b1;
  endtask

  // Cycle 0 is the cycle whose closing edge accepts start. mask bit c drives
  // start during cycle c; key is inverted in cycles without start. A write
  // and/or a reset may be injected in one given cycle (-1 = none).
  task automatic run_seq(input logic [WIDTH-1:0] k, input logic [31:0] mask,
                         input int wr_cyc, input int wa, input logic [WIDTH-1:0] wd,
                         input int rst_cyc, input int ncyc,
                         output int first_done, output int ndone, output bit r_hit,
                         output int r_idx, output int r_cnt,
                         output bit s_busy, output bit s_done, output bit s_hit);
    first_done = -1; ndone = 0; r_hit = 1'b0; r_idx = 0; r_cnt = 0;
    s_busy = 1'b1; s_done = 1'b1; s_hit = 1'b1;
    @(negedge clk);
    start = 1'b1; key = k;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = c; r_hit = hit; r_idx = int'(hit_idx); r_cnt = count_now();
        end
      end
      if (c == rst_cyc + 1) begin
        s_busy = busy; s_done = done; s_hit = hit;
      end
      start   = (c < 32) && mask[c];
      key     = start ? k : ~k;
      wr_en   = (c == wr_cyc);
      wr_addr = IDX_W'(wa);
      wr_data = wd;
      rst     = (c == rst_cyc);
    end
    start = 1'b0; wr_en = 1'b0; rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd, nd, ridx, rcnt, eidx, ecyc, ecnt;
    bit rh, sb, sd, sh, eh;
    logic [WIDTH-1:0] k;

    vecs[0]  = '{1, 0, 4'h0, 0, 0, 9,            0};
    vecs[1]  = '{0, 0, 4'h1, 0, 0, 0,            0};
    vecs[2]  = '{0, 5, 4'hA, 0, 0, 0,            0};
    vecs[3]  = '{1, 0, 4'h1, 1, 0, MC ? 9 : 2,   1};
    vecs[4]  = '{1, 0, 4'hA, 1, 5, MC ? 9 : 7,   1};
    vecs[5]  = '{0, 2, 4'hC, 0, 0, 0,            0};
    vecs[6]  = '{0, 6, 4'hC, 0, 0, 0,            0};
    vecs[7]  = '{1, 0, 4'hC, 1, 2, MC ? 9 : 4,   2};
    vecs[8]  = '{1, 0, 4'h0, 0, 0, 9,            0};
    vecs[9]  = '{0, 7, 4'h1, 0, 0, 0,            0};
    vecs[10] = '{1, 0, 4'h1, 1, 0, MC ? 9 : 2,   2};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; key = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_hit", int'(hit), 0);
    check("reset_hit_idx", int'(hit_idx), 0);

    for (int i = 0; i < NV; i++) begin
      if (!vecs[i].is_search) begin
        do_write(vecs[i].addr, vecs[i].data);
      end else begin
        run_seq(vecs[i].data, 32'h1, -1, 0, '0, -1, NCYC, fd, nd, rh, ridx, rcnt, sb, sd, sh);
        check($sformatf("vec%0d_done_cycle", i), fd, vecs[i].exp_cycle);
        check($sformatf("vec%0d_done_pulses", i), nd, 1);
        check($sformatf("vec%0d_hit", i), int'(rh), int'(vecs[i].exp_hit));
        check($sformatf("vec%0d_hit_idx", i), ridx, vecs[i].exp_idx);
`ifdef COMPARATOR_MATCH_COUNT_EN
        check($sformatf("vec%0d_match_count", i), rcnt, vecs[i].exp_count);
`endif
      end
    end

    // starts while busy (cycles 3 and 9) are dropped; cycle 10 is accepted
    run_seq(4'hF, 32'h0000_0609, -1, 0, '0, -1, 22, fd, nd, rh, ridx, rcnt, sb, sd, sh);
    check("busy_start_first_done", fd, 9);
    check("busy_start_done_pulses", nd, 2);
    check("busy_start_hit", int'(rh), 0);

    // entry 3 written with the key while entry 3 is being compared
    run_seq(4'h7, 32'h1, 4, 3, 4'h7, -1, NCYC, fd, nd, rh, ridx, rcnt, sb, sd, sh);
    m_word[3] = 4'h7; m_valid[3] = 1'b1;
    check("wr_during_scan_done", fd, 9);
    check("wr_during_scan_hit", int'(rh), 0);
    run_seq(4'h7, 32'h1, -1, 0, '0, -1, NCYC, fd, nd, rh, ridx, rcnt, sb, sd, sh);
    check("rerun_done", fd, MC ? 9 : 5);
    check("rerun_hit", int'(rh), 1);
    check("rerun_hit_idx", ridx, 3);

    // reset in cycle 4 of a scan for 4'hA (would hit at index 5)
    run_seq(4'hA, 32'h1, -1, 0, '0, 4, NCYC, fd, nd, rh, ridx, rcnt, sb, sd, sh);
    model_clear();
    check("midscan_rst_done_pulses", nd, 0);
    check("midscan_rst_busy", int'(sb), 0);
    check("midscan_rst_done", int'(sd), 0);
    check("midscan_rst_hit", int'(sh), 0);
    run_seq(4'hA, 32'h1, -1, 0, '0, -1, NCYC, fd, nd, rh, ridx, rcnt, sb, sd, sh);
    check("after_rst_done", fd, 9);
    check("after_rst_hit", int'(rh), 0);
    check("after_rst_hit_idx", ridx, 0);

    // randomized writes and searches against the table model
    for (int it = 0; it < 40; it++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) do_write($urandom_range(0, DEPTH - 1), WIDTH'($urandom));
      if ($urandom_range(0, 1) == 1) k = m_word[$urandom_range(0, DEPTH - 1)];
      else k = WIDTH'($urandom);
      model_search(k, eh, eidx, ecyc, ecnt);
      run_seq(k, 32'h1, -1, 0, '0, -1, NCYC, fd, nd, rh, ridx, rcnt, sb, sd, sh);
      check($sformatf("rnd%0d_done_cycle", it), fd, ecyc);
      check($sformatf("rnd%0d_done_pulses", it), nd, 1);
      check($sformatf("rnd%0d_hit", it), int'(rh), int'(eh));
      check($sformatf("rnd%0d_hit_idx", it), ridx, eidx);
`ifdef COMPARATOR_MATCH_COUNT_EN
      check($sformatf("rnd%0d_match_count", it), rcnt, ecnt);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
